// File: rtl/xbus_fabric_pkg.sv
// Shared definitions for the xbus fabric: FSM state encoding, default bus
// timeout and the system memory-map windows used to build SLV_BASE/SLV_MASK.
package xbus_fabric_pkg;

  typedef enum logic [1:0] {
    XBUS_IDLE = 2'd0,
    XBUS_WAIT = 2'd1,
    XBUS_RESP = 2'd2
  } xbus_state_t;

  localparam int XBUS_TIMEOUT_DEF = 15;

  // System memory map (12-bit controller address space)
  localparam logic [11:0] XBUS_REGF_BASE = 12'h000;
  localparam logic [11:0] XBUS_REGF_MASK = 12'hF00;
  localparam logic [11:0] XBUS_PROG_BASE = 12'h800;
  localparam logic [11:0] XBUS_PROG_MASK = 12'h800;
  localparam logic [11:0] XBUS_PS2_BASE  = 12'h100;
  localparam logic [11:0] XBUS_PS2_MASK  = 12'hFF0;
  localparam logic [11:0] XBUS_DISP_BASE = 12'h200;
  localparam logic [11:0] XBUS_DISP_MASK = 12'hF00;
  localparam logic [11:0] XBUS_OPER_BASE = 12'h300;
  localparam logic [11:0] XBUS_OPER_MASK = 12'hFF0;

endpackage

// File: rtl/xbus_fabric_match.sv
// Address window compare for all slaves plus a lowest-index priority encoder.
module xbus_fabric_match
  import xbus_fabric_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int N_SLV  = 8,
  parameter int IDX_W  = 3,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [N_SLV-1:0] match;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_win
    assign match[gi] = (addr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W];
  end

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit = |match;
    idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (match[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/xbus_fabric.sv
// Controller bus fabric: registered request stage, base/mask decode, per-slave
// wait handshake, timeout and error response. Optional XBUS_FABRIC_TRAP_EN adds an error trap.
module xbus_fabric
  import xbus_fabric_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int N_SLV   = 8,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '1,
  parameter int TIMEOUT = XBUS_TIMEOUT_DEF,
  parameter int TO_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_sel,
  input  logic                    m_we,
  input  logic [ADDR_W-1:0]       m_addr,
  input  logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W-1:0]       m_rdata,
  output logic                    m_ready,
  output logic                    m_err,
  output logic [N_SLV-1:0]        s_sel,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_addr,
  output logic [DATA_W-1:0]       s_wdata,
  input  logic [N_SLV*DATA_W-1:0] s_rdata,
`ifdef XBUS_FABRIC_TRAP_EN
  output logic                    trap_valid,
  output logic [ADDR_W-1:0]       trap_addr,
  input  logic                    trap_clr,
`endif
  input  logic [N_SLV-1:0]        s_ready
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  // The counter holds completed wait cycles, so expiry lands on the TIMEOUT-th WAIT cycle.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  xbus_state_t        state_reg;
  logic [IDX_W-1:0]   sel_idx_reg;
  logic [TO_W-1:0]    to_cnt_reg;
  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               to_expire;
  logic               sel_ready;
  logic [DATA_W-1:0]  s_rdata_arr [N_SLV];

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_rdata
    assign s_rdata_arr[gi] = s_rdata[gi*DATA_W +: DATA_W];
  end

  xbus_fabric_match #(
    .ADDR_W   (ADDR_W),
    .N_SLV    (N_SLV),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_match (
    .addr (m_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  assign sel_ready = s_ready[sel_idx_reg];
  assign to_expire = TO_EN && (to_cnt_reg == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= XBUS_IDLE;
      sel_idx_reg <= '0;
      to_cnt_reg  <= '0;
      s_sel       <= '0;
      s_we        <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      m_rdata     <= '0;
      m_ready     <= 1'b0;
      m_err       <= 1'b0;
    end else begin
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      case (state_reg)
        XBUS_IDLE: begin
          if (m_sel) begin
            if (dec_hit) begin
              s_addr      <= m_addr;
              s_wdata     <= m_wdata;
              s_we        <= m_we;
              s_sel       <= N_SLV'(1) << dec_idx;
              sel_idx_reg <= dec_idx;
              to_cnt_reg  <= '0;
              state_reg   <= XBUS_WAIT;
            end else begin
              m_err     <= 1'b1;
              m_ready   <= 1'b1;
              m_rdata   <= '0;
              state_reg <= XBUS_RESP;
            end
          end
        end
        XBUS_WAIT: begin
          // A ready arriving on the expiry cycle still completes cleanly.
          if (sel_ready) begin
            m_rdata   <= s_we ? '0 : s_rdata_arr[sel_idx_reg];
            m_ready   <= 1'b1;
            s_sel     <= '0;
            state_reg <= XBUS_RESP;
          end else if (to_expire) begin
            m_rdata   <= '0;
            m_err     <= 1'b1;
            m_ready   <= 1'b1;
            s_sel     <= '0;
            state_reg <= XBUS_RESP;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        XBUS_RESP: state_reg <= XBUS_IDLE;
        default:   state_reg <= XBUS_IDLE;
      endcase
    end
  end

`ifdef XBUS_FABRIC_TRAP_EN
  logic              trap_hit;
  logic [ADDR_W-1:0] trap_src;

  always_comb begin
    trap_hit = 1'b0;
    trap_src = m_addr;
    if (state_reg == XBUS_IDLE && m_sel && !dec_hit) begin
      trap_hit = 1'b1;
    end else if (state_reg == XBUS_WAIT && !sel_ready && to_expire) begin
      trap_hit = 1'b1;
      trap_src = s_addr;
    end
  end

  // A clear in the same cycle as a new error makes room for the new capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_valid <= 1'b0;
      trap_addr  <= '0;
    end else if (trap_hit && (!trap_valid || trap_clr)) begin
      trap_valid <= 1'b1;
      trap_addr  <= trap_src;
    end else if (trap_clr) begin
      trap_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_xbus_fabric.sv
// Self-checking bench for xbus_fabric: directed scenarios plus randomized
// traffic against a transaction-level reference model (trap checks with XBUS_FABRIC_TRAP_EN).
module tb_xbus_fabric;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int N_SLV   = 8;
  localparam int TIMEOUT = 15;
  localparam int TO_W    = 4;

  localparam logic [11:0] BASE_TAB [N_SLV] = '{12'h000, 12'h200, 12'h100, 12'h200,
                                               12'h300, 12'h400, 12'h600, 12'h800};
  localparam logic [11:0] MASK_TAB [N_SLV] = '{12'hF00, 12'hF80, 12'hFF0, 12'hF00,
                                               12'hF00, 12'hE00, 12'hF00, 12'hC00};
  localparam logic [N_SLV*ADDR_W-1:0] SLV_BASE =
    {12'h800, 12'h600, 12'h400, 12'h300, 12'h200, 12'h100, 12'h200, 12'h000};
  localparam logic [N_SLV*ADDR_W-1:0] SLV_MASK =
    {12'hC00, 12'hF00, 12'hE00, 12'hF00, 12'hF00, 12'hFF0, 12'hF80, 12'hF00};

  logic                    clk;
  logic                    rst;
  logic                    m_sel;
  logic                    m_we;
  logic [ADDR_W-1:0]       m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_ready;
  logic                    m_err;
  logic [N_SLV-1:0]        s_sel;
  logic                    s_we;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [N_SLV*DATA_W-1:0] s_rdata;
  logic [N_SLV-1:0]        s_ready;
`ifdef XBUS_FABRIC_TRAP_EN
  logic                    trap_valid;
  logic [ADDR_W-1:0]       trap_addr;
  logic                    trap_clr;
  bit                      tv_m;
  logic [ADDR_W-1:0]       ta_m;
`endif

  int          lat [N_SLV];      // WAIT cycle on which each slave answers; 0 = never
  logic [31:0] rd_val [N_SLV];
  logic [7:0]  stray;
  int          sel_cnt [N_SLV];
  int          n_checks;
  int          n_fail;

  xbus_fabric #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (TO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_sel      (m_sel),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .m_ready    (m_ready),
    .m_err      (m_err),
    .s_sel      (s_sel),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata),
`ifdef XBUS_FABRIC_TRAP_EN
    .trap_valid (trap_valid),
    .trap_addr  (trap_addr),
    .trap_clr   (trap_clr),
`endif
    .s_ready    (s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @* begin
    for (int i = 0; i < N_SLV; i++) s_rdata[i*DATA_W +: DATA_W] = rd_val[i];
  end

  // Slave models: count cycles of own select, answer on the configured one.
  always @(negedge clk) begin
    for (int i = 0; i < N_SLV; i++) begin
      if (s_sel[i]) sel_cnt[i] = sel_cnt[i] + 1;
      else          sel_cnt[i] = 0;
      s_ready[i] = (s_sel[i] && lat[i] != 0 && sel_cnt[i] == lat[i]) || stray[i];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int ref_idx(input logic [11:0] a);
    for (int i = 0; i < N_SLV; i++) begin
      if ((a & MASK_TAB[i]) == BASE_TAB[i]) return i;
    end
    return -1;
  endfunction

  task automatic run_txn(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                         input bit b2b);
    int idx, exp_lat, cyc;
    bit done;
    logic exp_err;
    logic [31:0] exp_rd;
    logic [7:0] exp_sel;
`ifdef XBUS_FABRIC_TRAP_EN
    bit clr_now;
    clr_now = trap_clr;
`endif
    idx = ref_idx(addr);
    exp_sel = 8'h00;
    if (idx < 0) begin
      exp_lat = 1; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_sel = 8'(1 << idx);
      if (lat[idx] != 0 && lat[idx] <= TIMEOUT) begin
        exp_lat = lat[idx] + 1; exp_err = 1'b0; exp_rd = we ? 32'h0 : rd_val[idx];
      end else begin
        exp_lat = TIMEOUT + 1; exp_err = 1'b1; exp_rd = '0;
      end
    end
    m_sel = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata;
    @(posedge clk);
`ifdef XBUS_FABRIC_TRAP_EN
    #1 trap_clr = 1'b0;
`endif
    done = 0;
    cyc = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      cyc = c;
      n_checks++;
      if (s_sel !== ((c < exp_lat) ? exp_sel : 8'h00)) begin
        n_fail++;
        $display("FAIL s_sel addr=%h cycle=%0d got=%b exp=%b", addr, c, s_sel,
                 (c < exp_lat) ? exp_sel : 8'h00);
      end
      if (s_sel != 0) begin
        n_checks++;
        if ({s_we, s_addr, s_wdata} !== {we, addr, wdata}) begin
          n_fail++;
          $display("FAIL s_req addr=%h cycle=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                   addr, c, s_we, s_addr, s_wdata, we, addr, wdata);
        end
      end
      if (m_ready === 1'b1) done = 1;
    end
    n_checks++;
    if (!done || cyc != exp_lat) begin
      n_fail++;
      $display("FAIL latency addr=%h got=%0d (ready=%0d) exp=%0d", addr, cyc, done, exp_lat);
    end
    n_checks++;
    if ({m_err, m_rdata} !== {exp_err, exp_rd}) begin
      n_fail++;
      $display("FAIL resp addr=%h got err=%b rdata=%h exp err=%b rdata=%h",
               addr, m_err, m_rdata, exp_err, exp_rd);
    end
`ifdef XBUS_FABRIC_TRAP_EN
    if (exp_err && (!tv_m || clr_now)) begin
      tv_m = 1; ta_m = addr;
    end else if (clr_now) begin
      tv_m = 0;
    end
    n_checks++;
    if (trap_valid !== tv_m || trap_addr !== ta_m) begin
      n_fail++;
      $display("FAIL trap addr=%h got v=%b a=%h exp v=%b a=%h", addr, trap_valid, trap_addr,
               tv_m, ta_m);
    end
`endif
    $display("txn we=%b addr=%h idx=%0d lat=%0d err=%b rdata=%h", we, addr, idx, cyc, m_err,
             m_rdata);
    @(posedge clk);
    #1 m_sel = 1'b0;
    if (!b2b) begin
      @(negedge clk);
      n_checks++;
      if (m_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_pulse addr=%h got=%b exp=0", addr, m_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (s_sel !== '0 || {s_we, s_addr, s_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_slave got sel=%b we=%b a=%h d=%h exp all 0", s_sel, s_we, s_addr, s_wdata);
    end
    n_checks++;
    if ({m_ready, m_err} !== 2'b00 || m_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_master got rdy=%b err=%b rdata=%h exp 0", m_ready, m_err, m_rdata);
    end
`ifdef XBUS_FABRIC_TRAP_EN
    n_checks++;
    if (trap_valid !== 1'b0 || trap_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_trap got v=%b a=%h exp 0", trap_valid, trap_addr);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    $display("txn reset done");
  endtask

  task automatic test_zero_wait();
    lat[2] = 1; rd_val[2] = 32'hDEADBEEF;
    run_txn(1'b0, 12'h104, $urandom, 1'b0);
  endtask

  task automatic test_wait_states();
    lat[0] = 5;
    run_txn(1'b1, 12'h010, 32'h55, 1'b0);
  endtask

  task automatic test_unmapped();
    run_txn(1'b0, 12'hFFF, 32'h0, 1'b0);
    run_txn(1'b1, 12'h7A0, 32'h1234, 1'b0);
  endtask

  task automatic test_timeout();
    rd_val[4] = 32'hCAFE0004;
    lat[4] = 0;  run_txn(1'b0, 12'h3A0, 32'h0, 1'b0);
    lat[4] = 15; run_txn(1'b0, 12'h3A4, 32'h0, 1'b0);
    lat[4] = 16; run_txn(1'b1, 12'h3A8, 32'h77, 1'b0);
  endtask

  task automatic test_overlap();
    lat[1] = 3; lat[3] = 1;
    rd_val[1] = 32'h11111111; rd_val[3] = 32'h33333333;
    stray = 8'h08;
    run_txn(1'b0, 12'h200, 32'h0, 1'b0);
    stray = 8'h00;
    run_txn(1'b0, 12'h2C0, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    lat[2] = 1; lat[5] = 2; rd_val[5] = 32'h5A5A0005;
    run_txn(1'b0, 12'h10C, 32'h0, 1'b1);
    run_txn(1'b0, 12'h5F0, 32'h0, 1'b1);
    run_txn(1'b0, 12'hE00, 32'h0, 1'b1);
    run_txn(1'b1, 12'h104, 32'h9, 1'b0);
  endtask

  task automatic test_reset_abort();
    lat[6] = 0;
    m_sel = 1'b1; m_we = 1'b0; m_addr = 12'h650; m_wdata = '0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (s_sel !== 8'h40) begin
      n_fail++;
      $display("FAIL abort_pre got sel=%b exp=01000000", s_sel);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (s_sel !== 8'h00 || m_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async got sel=%b rdy=%b exp 0/0", s_sel, m_ready);
    end
    m_sel = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`ifdef XBUS_FABRIC_TRAP_EN
    tv_m = 0; ta_m = '0;
`endif
    $display("txn reset abort");
    lat[6] = 2;
    run_txn(1'b1, 12'h6F0, $urandom, 1'b0);
  endtask

  task automatic test_random();
    logic [11:0] a;
    int idx;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N_SLV; i++) begin
        lat[i] = $urandom_range(0, 17);
        rd_val[i] = $urandom;
      end
      a = 12'($urandom);
      idx = ref_idx(a);
      stray = 8'($urandom) & ((idx >= 0) ? ~8'(1 << idx) : 8'hFF);
      run_txn(1'($urandom), a, $urandom, 1'($urandom_range(0, 1)));
    end
    stray = 8'h00;
    @(negedge clk);
  endtask

`ifdef XBUS_FABRIC_TRAP_EN
  task automatic test_trap();
    trap_clr = 1'b1;
    @(posedge clk);
    #1 trap_clr = 1'b0;
    tv_m = 0;
    n_checks++;
    if (trap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_clear got=%b exp=0", trap_valid);
    end
    run_txn(1'b0, 12'h700, 32'h0, 1'b0);
    run_txn(1'b0, 12'hC34, 32'h0, 1'b0);
    trap_clr = 1'b1;
    run_txn(1'b1, 12'hD00, 32'h1, 1'b0);
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0;
    m_sel = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    stray = 8'h00;
    for (int i = 0; i < N_SLV; i++) begin
      lat[i] = 1; rd_val[i] = '0; sel_cnt[i] = 0;
    end
`ifdef XBUS_FABRIC_TRAP_EN
    trap_clr = 1'b0; tv_m = 0; ta_m = '0;
`endif
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_unmapped();
    test_timeout();
    test_overlap();
    test_back_to_back();
    test_reset_abort();
`ifdef XBUS_FABRIC_TRAP_EN
    test_trap();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xbus_fabric.md
Name: xbus_fabric

Overview:
- Parametrised successor to the hard-coded top-level address decoder and read-data mux.
- Sits between the controller data bus (master side) and N_SLV peripheral slaves (regf, prog, ps2, disp, oper, and future blocks).
- Adds a registered request stage, per-slave wait-state handshake, a bus timeout, and an error response for unmapped or timed-out accesses.
- Replaces the fixed if/else chain with programmable base/mask windows.

Parameters:
- ADDR_W, 12, address width.
- DATA_W, 32, data width.
- N_SLV, 8, number of slave ports (1..16).
- SLV_BASE, all zero, packed N_SLV*ADDR_W; base address of each window.
- SLV_MASK, all ones, packed N_SLV*ADDR_W; a window matches when (m_addr & mask) == base.
- TIMEOUT, 15, maximum WAIT cycles before an error response; 0 disables the timeout.
- TO_W, 4, counter width; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- m_sel  input  1  master request; held stable until m_ready.
- m_we  input  1  master write enable.
- m_addr  input  ADDR_W  master address.
- m_wdata  input  DATA_W  master write data.
- m_rdata  output  DATA_W  registered read data, valid with m_ready.
- m_ready  output  1  one-cycle completion pulse.
- m_err  output  1  error flag, valid with m_ready.
- s_sel  output  N_SLV  one-hot slave select.
- s_we  output  1  registered write enable.
- s_addr  output  ADDR_W  registered address.
- s_wdata  output  DATA_W  registered write data.
- s_rdata  input  N_SLV*DATA_W  packed slave read data.
- s_ready  input  N_SLV  slave completion; sampled only for the selected slave.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; s_sel=0, s_we=0, s_addr=0, s_wdata=0, m_rdata=0, m_ready=0, m_err=0, counter=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE, m_sel=1: decode m_addr against all windows; the lowest matching index wins.
  - Hit: register s_addr, s_wdata, s_we; set s_sel[idx]; clear counter; go to WAIT.
  - Miss: m_err<=1, m_rdata<=0; go to RESP. No slave is selected.
- WAIT: s_sel held one-hot.
  - s_ready[idx]=1: latch m_rdata<=s_rdata[idx] (reads) or 0 (writes); m_err<=0; s_sel<=0; go to RESP.
  - Otherwise counter++. When counter==TIMEOUT and TIMEOUT!=0: s_sel<=0, m_err<=1, m_rdata<=0; go to RESP.
  - s_ready on the same cycle as the timeout: ready wins, no error.
- RESP: m_ready=1 for exactly one cycle; go to IDLE. m_sel is ignored in RESP.
- Minimum latency: m_sel sampled at edge 0; s_sel visible in cycle 1; with a zero-wait slave (s_ready=1 in cycle 1), m_ready is high in cycle 2. Unmapped access: m_ready in cycle 1.
- A new request is accepted only in IDLE. The master drops m_sel on the edge after m_ready, so back-to-back accesses have a minimum spacing of 3 cycles.
- s_ready on non-selected slaves, and any s_ready in IDLE or RESP, is ignored.
- Reset mid-transaction aborts immediately; the slave sees s_sel drop asynchronously.
- m_ready and m_err are cleared in every state except RESP.

Optional Feature:
- Macro XBUS_FABRIC_TRAP_EN.
- Defined:
  - Extra ports: trap_valid (output, 1), trap_addr (output, ADDR_W), trap_clr (input, 1).
  - On the first error response, trap_valid<=1 and trap_addr<=the offending address.
  - Later errors do not overwrite the captured address while trap_valid=1.
  - trap_clr clears trap_valid. If trap_clr and a new error occur in the same cycle, the new error is captured.
  - Both trap outputs reset to 0.
- Undefined: these ports and registers do not exist; errors are reported only via m_err.

Decomposition:
- Shared package (xbusdefs.vh):
  - state encodings XBUS_IDLE/WAIT/RESP;
  - default TIMEOUT;
  - system memory-map base/mask constants (REGF, PROG, PS2, DISP, OPER) used to build SLV_BASE/SLV_MASK at the top level.
- One combinational sub-module, xbus_match: window compare plus lowest-index priority encoder, producing hit and idx.

Test Plan:
- Zero-wait read: slave 2 at base 0x100, mask 0xFF0, returns 0xDEADBEEF with s_ready tied high; m_addr=0x104 read → s_sel=0b100 in cycle 1, m_ready with m_rdata=0xDEADBEEF, m_err=0 in cycle 2.
- Wait states: slave 0 asserts s_ready after 5 cycles; write 0x55 to its address → s_wdata=0x55 held for 5 cycles, m_ready 1 cycle later, m_rdata=0, m_err=0.
- Unmapped: m_addr=0xFFF with no matching window → m_ready and m_err=1 in cycle 1, m_rdata=0, s_sel never asserted; with XBUS_FABRIC_TRAP_EN, trap_addr=0xFFF and trap_valid=1.
- Timeout: TIMEOUT=15, selected slave never ready → s_sel drops after 15 WAIT cycles, then m_ready with m_err=1. Repeat with s_ready on cycle 15 → no error.
- Overlap priority: slaves 1 and 3 both match 0x200 → only s_sel[1] asserted. Stray s_ready[3] during WAIT is ignored.
- Reset abort: assert rst low mid-WAIT → s_sel=0 and m_ready=0 immediately; after release, IDLE accepts a new request normally.
